// File: rtl/can_clic_arbiter.sv
// Interrupt arbiter with per-source priority, enable and pending state, plus a nesting stack of running levels.
// Latency: a source event reaches is_interrupt/index/prio two rising edges later (pending latch, then output register).
// Backpressure: the presented candidate is held until take_i accepts it or a better or ineligible state replaces it; no input-to-output paths.
//
// Ports:
//   clk, rst             sole clock; synchronous active-high reset
//   irq_i                raw source lines
//   cfg_we/idx/prio/en   per-entry configuration write
//   take_i, ret_i        core accepts presented interrupt / returns from handler
//   is_interrupt, index, prio   registered candidate presentation
//   level, depth         running priority level and nesting depth
//
// Build option: define CAN_CLIC_EDGE_EN for edge-triggered pending bits
// (set on a rising source edge, cleared by take). Otherwise pending follows
// the source level, registered once per cycle.
module can_clic_arbiter #(
  parameter int NUM_IRQ   = 8,
  parameter int PRIO_BITS = 3,
  parameter int IDX_W     = $clog2(NUM_IRQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_IRQ-1:0]   irq_i,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [PRIO_BITS-1:0] cfg_prio,
  input  logic                 cfg_en,
  input  logic                 take_i,
  input  logic                 ret_i,
  output logic                 is_interrupt,
  output logic [IDX_W-1:0]     index,
  output logic [PRIO_BITS-1:0] prio,
  output logic [PRIO_BITS-1:0] level,
  output logic [PRIO_BITS-1:0] depth
);

  // Level strictly rises per take, so at most 2**PRIO_BITS-1 saved levels.
  localparam int STK = 2**PRIO_BITS - 1;

  logic [PRIO_BITS-1:0] prio_r [NUM_IRQ];
  logic [NUM_IRQ-1:0]   en_r;
  logic [NUM_IRQ-1:0]   pend_r;
  logic [NUM_IRQ-1:0]   pend_nxt;
  logic [PRIO_BITS-1:0] stack [STK];

  logic                 win_vld;
  logic [IDX_W-1:0]     win_idx;
  logic [PRIO_BITS-1:0] win_prio;
  logic                 take_ok;
  logic                 ret_ok;

  // Take wins over a simultaneous return; return at depth 0 is a no-op.
  assign take_ok = take_i & is_interrupt;
  assign ret_ok  = ret_i & ~take_i & (depth != '0);

  // Ascending scan with strict '>' keeps the lowest index on priority ties.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    win_prio = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (pend_r[i] && en_r[i] && (prio_r[i] > level) &&
          (!win_vld || (prio_r[i] > win_prio))) begin
        win_vld  = 1'b1;
        win_idx  = IDX_W'(i);
        win_prio = prio_r[i];
      end
    end
  end

`ifdef CAN_CLIC_EDGE_EN
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] take_mask;

  // A new rising edge on the entry being taken keeps its pending bit set.
  always_comb begin
    take_mask = '0;
    if (take_ok) take_mask[index] = 1'b1;
    pend_nxt = (pend_r & ~take_mask) | (irq_i & ~irq_q);
  end

  always_ff @(posedge clk) begin
    if (rst) irq_q <= '0;
    else     irq_q <= irq_i;
  end
`else
  // Level mode: take leaves pending alone; the raised level masks the
  // entry until the handler returns.
  always_comb begin
    pend_nxt = irq_i;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r       <= '0;
      en_r         <= '0;
      is_interrupt <= 1'b0;
      index        <= '0;
      prio         <= '0;
      level        <= '0;
      depth        <= '0;
      for (int i = 0; i < NUM_IRQ; i++) prio_r[i] <= '0;
      for (int i = 0; i < STK; i++)     stack[i]  <= '0;
    end else begin
      pend_r <= pend_nxt;

      for (int i = 0; i < NUM_IRQ; i++) begin
        if (cfg_we && (cfg_idx == IDX_W'(i))) begin
          prio_r[i] <= cfg_prio;
          en_r[i]   <= cfg_en;
        end
      end

      if (take_ok) begin
        stack[depth] <= level;
        level        <= prio;
        depth        <= depth + PRIO_BITS'(1);
        is_interrupt <= 1'b0;
      end else begin
        if (ret_ok) begin
          level <= stack[depth - PRIO_BITS'(1)];
          depth <= depth - PRIO_BITS'(1);
        end
        // Evaluated against the level held before this edge, so a return
        // lets lower entries through one edge later.
        is_interrupt <= win_vld;
        if (win_vld) begin
          index <= win_idx;
          prio  <= win_prio;
        end
      end
    end
  end

endmodule

// File: tb/tb_can_clic_arbiter.sv
module tb_can_clic_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_i;
  logic       cfg_we;
  logic [2:0] cfg_idx;
  logic [2:0] cfg_prio;
  logic       cfg_en;
  logic       take_i;
  logic       ret_i;
  logic       is_interrupt;
  logic [2:0] index;
  logic [2:0] prio;
  logic [2:0] level;
  logic [2:0] depth;

  always #5 clk = ~clk;

  can_clic_arbiter dut (
    .clk(clk), .rst(rst), .irq_i(irq_i),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_prio(cfg_prio), .cfg_en(cfg_en),
    .take_i(take_i), .ret_i(ret_i),
    .is_interrupt(is_interrupt), .index(index), .prio(prio),
    .level(level), .depth(depth)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: arrays per entry, a queue as the level stack.
  int m_pr [8];
  bit m_en [8];
  bit m_pend [8];
  bit m_prev [8];
  bit m_is;
  int m_idx, m_opr, m_lvl;
  int m_stk[$];

  logic [12:0] exp_q[$];

  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, got, want);
  endtask

  // Monitor: the DUT presents a fresh registered state after every edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [12:0] e;
      e = exp_q.pop_front();
      chk("scoreboard {is,idx,prio,level,depth}",
          int'({is_interrupt, index, prio, level, depth}), int'(e));
    end
  end

  // Applies the rules to the inputs about to be sampled and pushes the
  // state the DUT must show after that edge.
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_pr[i] = 0; m_en[i] = 0; m_pend[i] = 0; m_prev[i] = 0;
      end
      m_is = 0; m_idx = 0; m_opr = 0; m_lvl = 0;
      m_stk.delete();
    end else begin
      bit tk;
      int best;
      bit pn [8];
      tk = take_i && m_is;
      best = -1;
      for (int i = 0; i < 8; i++)
        if (m_pend[i] && m_en[i] && m_pr[i] > m_lvl &&
            (best < 0 || m_pr[i] > m_pr[best])) best = i;
      for (int i = 0; i < 8; i++) begin
`ifdef CAN_CLIC_EDGE_EN
        pn[i] = (m_pend[i] && !(tk && m_idx == i)) || (irq_i[i] && !m_prev[i]);
`else
        pn[i] = irq_i[i];
`endif
      end
      if (tk) begin
        m_stk.push_back(m_lvl);
        m_lvl = m_opr;
        m_is = 0;
      end else begin
        if (ret_i && m_stk.size() > 0) m_lvl = m_stk.pop_back();
        if (best >= 0) begin
          m_is = 1; m_idx = best; m_opr = m_pr[best];
        end else m_is = 0;
      end
      if (cfg_we) begin
        m_pr[cfg_idx] = int'(cfg_prio);
        m_en[cfg_idx] = cfg_en;
      end
      for (int i = 0; i < 8; i++) begin
        m_pend[i] = pn[i];
        m_prev[i] = irq_i[i];
      end
    end
    exp_q.push_back({m_is, 3'(m_idx), 3'(m_opr), 3'(m_lvl), 3'(m_stk.size())});
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    rst = 0; cfg_we = 0; take_i = 0; ret_i = 0;
  endtask

  task automatic do_reset();
    rst = 1; cyc();
    rst = 1; cyc();
  endtask

  task automatic cfg(input int i, input int p, input bit e);
    cfg_we = 1; cfg_idx = 3'(i); cfg_prio = 3'(p); cfg_en = e;
    cyc();
  endtask

  task automatic take();
    take_i = 1; cyc();
  endtask

  task automatic ret();
    ret_i = 1; cyc();
  endtask

  initial begin
    rst = 1; irq_i = '0; cfg_we = 0; cfg_idx = '0; cfg_prio = '0; cfg_en = 0;
    take_i = 0; ret_i = 0;
    do_reset();
    chk("reset is_interrupt", int'(is_interrupt), 0);
    chk("reset index/prio", int'({index, prio}), 0);
    chk("reset level/depth", int'({level, depth}), 0);

    // Priority 0 never interrupts.
    for (int i = 0; i < 8; i++) cfg(i, 0, 1);
    irq_i = 8'hFF; cyc();
    irq_i = 8'h00; cyc(); cyc(); cyc();
    chk("prio0 silent", int'(is_interrupt), 0);

    // Tie on priority goes to the lower index, two edges after the event.
    do_reset();
    cfg(2, 3, 1); cfg(5, 3, 1);
    irq_i = 8'h24; cyc();
    irq_i = 8'h00; cyc();
    chk("tie present", int'({is_interrupt, index, prio}), int'({1'b1, 3'd2, 3'd3}));
    cyc(); cyc();

    // Nesting.
    do_reset();
    cfg(1, 2, 1); cfg(4, 5, 1);
    irq_i = 8'h02; cyc(); cyc();
    chk("nest present 1", int'({is_interrupt, index}), int'({1'b1, 3'd1}));
    take();
    chk("nest take 1", int'({is_interrupt, level, depth}), int'({1'b0, 3'd2, 3'd1}));
    irq_i = 8'h10; cyc(); cyc();
    chk("nest present 4", int'({is_interrupt, index, prio}), int'({1'b1, 3'd4, 3'd5}));
    take();
    chk("nest take 4", int'({level, depth}), int'({3'd5, 3'd2}));
    irq_i = 8'h00;
    ret();
    chk("nest ret 1", int'({level, depth}), int'({3'd2, 3'd1}));
    ret();
    chk("nest ret 2", int'({level, depth}), 0);

    // Lower priority blocked until level drops below it.
    do_reset();
    cfg(0, 4, 1); cfg(4, 5, 1);
    irq_i = 8'h10; cyc(); cyc();
    take();
    irq_i = 8'h11; cyc(); cyc(); cyc();
    chk("blocked by level", int'(is_interrupt), 0);
    irq_i = 8'h01;
    ret();
    chk("ret edge uses old level", int'({is_interrupt, level}), 0);
    cyc();
    chk("unblocked", int'({is_interrupt, index}), int'({1'b1, 3'd0}));
    take(); irq_i = 8'h00; ret(); cyc();

    // Return at depth 0, then take+ret together.
    do_reset();
    ret();
    chk("ret at depth0", int'({level, depth}), 0);
    cfg(3, 1, 1);
    irq_i = 8'h08; cyc(); cyc();
    chk("entry3 present", int'({is_interrupt, index, prio}), int'({1'b1, 3'd3, 3'd1}));
    take_i = 1; ret_i = 1; cyc();
    chk("take beats ret", int'({level, depth}), int'({3'd1, 3'd1}));
    irq_i = 8'h00; ret();

    // Source held high across the handler.
    do_reset();
    cfg(6, 2, 1);
    irq_i = 8'h40; cyc(); cyc();
    chk("entry6 present", int'({is_interrupt, index}), int'({1'b1, 3'd6}));
    take(); cyc(); cyc(); cyc();
    chk("held during handler", int'(is_interrupt), 0);
    ret(); cyc();
`ifdef CAN_CLIC_EDGE_EN
    chk("held after ret", int'(is_interrupt), 0);
`else
    chk("held after ret", int'(is_interrupt), 1);
`endif
    irq_i = 8'h00; cyc();
    irq_i = 8'h40; cyc(); cyc();
    chk("re-raised", int'({is_interrupt, index}), int'({1'b1, 3'd6}));

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 8; i++) cfg(i, int'($urandom_range(7)), 1);
    for (int c = 0; c < 3000; c++) begin
      irq_i = irq_i ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(9) == 0) begin
        cfg_we = 1; cfg_idx = 3'($urandom); cfg_prio = 3'($urandom);
        cfg_en = ($urandom_range(3) != 0);
      end
      take_i = m_is && ($urandom_range(1) == 1);
      ret_i  = ($urandom_range(5) == 0);
      rst    = ($urandom_range(499) == 0);
      cyc();
    end

    @(negedge clk);
    #1;
    chk("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
